// File: rtl/fsm_full_pkg.sv
// Shared types and constants for the four-requester fixed-priority arbiter.
package fsm_full_pkg;

  localparam int NUM_REQ = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    GNT0 = 3'd1,
    GNT1 = 3'd2,
    GNT2 = 3'd3,
    GNT3 = 3'd4
  } state_t;

  // Grant state owned by requester idx (GNTi is encoded as i+1).
  function automatic state_t grant_state(input int idx);
    return state_t'(3'(idx + 1));
  endfunction

endpackage

// File: rtl/fsm_full_arbiter.sv
// Fixed-priority, non-preemptive arbiter for four agents sharing one resource.
// Moore FSM; grants are decoded from the state register and registered again.
module fsm_full_arbiter
  import fsm_full_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic req_0,
  input  logic req_1,
  input  logic req_2,
  input  logic req_3,
  output logic gnt_0,
  output logic gnt_1,
  output logic gnt_2,
  output logic gnt_3
);

  state_t state_q, state_d;
  logic [NUM_REQ-1:0] gnt_q;

  // Priority only matters in IDLE; an owner keeps the resource until it lets go,
  // and every release goes back through IDLE before anyone else is considered.
  always_comb begin
    state_d = IDLE;
    case (state_q)
      IDLE: begin
        if (req_0)      state_d = GNT0;
        else if (req_1) state_d = GNT1;
        else if (req_2) state_d = GNT2;
        else if (req_3) state_d = GNT3;
        else            state_d = IDLE;
      end
      GNT0:    state_d = req_0 ? GNT0 : IDLE;
      GNT1:    state_d = req_1 ? GNT1 : IDLE;
      GNT2:    state_d = req_2 ? GNT2 : IDLE;
      GNT3:    state_d = req_3 ? GNT3 : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Grants follow the state register one cycle later.
  always_ff @(posedge clock) begin
    if (reset) begin
      gnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        gnt_q[i] <= (state_q == grant_state(i));
      end
    end
  end

  assign gnt_0 = gnt_q[0];
  assign gnt_1 = gnt_q[1];
  assign gnt_2 = gnt_q[2];
  assign gnt_3 = gnt_q[3];

endmodule

// File: tb/tb_fsm_full_arbiter.sv
// Self-checking bench for fsm_full_arbiter: directed scenarios with literal
// expectations, then randomized traffic checked against an ownership model.
module tb_fsm_full_arbiter;

  logic       clock;
  logic       reset;
  logic [3:0] req;
  logic [3:0] gnt;

  int total = 0;
  int bad   = 0;

  fsm_full_arbiter dut (
    .clock (clock),
    .reset (reset),
    .req_0 (req[0]),
    .req_1 (req[1]),
    .req_2 (req[2]),
    .req_3 (req[3]),
    .gnt_0 (gnt[0]),
    .gnt_1 (gnt[1]),
    .gnt_2 (gnt[2]),
    .gnt_3 (gnt[3])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Model: who owns the resource (-1 = nobody) and the grant vector that
  // should be visible after the current edge (previous owner, one-hot).
  int         owner       = -1;
  logic [3:0] exp_gnt     = 4'b0000;
  logic [3:0] req_prev1   = 4'b0000;
  logic [3:0] req_prev2   = 4'b0000;
  bit         model_valid = 1'b0;

  always @(posedge clock) begin
    model_valid = 1'b1;
    req_prev2   = req_prev1;
    req_prev1   = req;
    if (reset) begin
      owner   = -1;
      exp_gnt = 4'b0000;
    end else begin
      exp_gnt = (owner >= 0) ? 4'(1 << owner) : 4'b0000;
      if (owner < 0) begin
        for (int i = 0; i < 4; i++) begin
          if (req[i] && owner < 0) owner = i;
        end
      end else if (!req[owner]) begin
        owner = -1;
      end
    end
  end

  // Per-cycle compare against the model plus structural invariants.
  always @(negedge clock) begin
    if (model_valid) begin
      total++;
      if (gnt !== exp_gnt) begin
        bad++;
        $display("FAIL model_cmp t=%0t gnt=%b expected=%b", $time, gnt, exp_gnt);
      end
      total++;
      if ($countones(gnt) > 1) begin
        bad++;
        $display("FAIL onehot t=%0t gnt=%b expected at most one bit", $time, gnt);
      end
      total++;
      if ((gnt & ~req_prev2) != 4'b0000) begin
        bad++;
        $display("FAIL req_history t=%0t gnt=%b req_two_edges_ago=%b", $time, gnt, req_prev2);
      end
    end
  end

  task automatic check(input string name, input logic [3:0] got, input logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s gnt=%b expected=%b", name, got, want);
    end
    $display("txn %s gnt=%b expected=%b", name, got, want);
  endtask

  // Drive one sampled cycle: apply inputs at a negedge, return at the next negedge.
  task automatic cyc(input logic [3:0] r, input logic rs);
    req   = r;
    reset = rs;
    @(negedge clock);
  endtask

  logic [3:0] onehot;
  logic [3:0] rnd_req;

  initial begin
    reset = 1'b1;
    req   = 4'b1111;
    @(negedge clock);

    // Reset held with all requests high, then released with requests idle.
    cyc(4'b1111, 1'b1);
    cyc(4'b1111, 1'b1);
    check("reset_held", gnt, 4'b0000);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    check("reset_released_idle", gnt, 4'b0000);

    // Each agent alone for five sampled edges.
    for (int a = 0; a < 4; a++) begin
      onehot = 4'(1 << a);
      cyc(onehot, 1'b0);
      check($sformatf("single%0d_first_edge", a), gnt, 4'b0000);
      for (int k = 2; k <= 5; k++) begin
        cyc(onehot, 1'b0);
        check($sformatf("single%0d_hold%0d", a, k), gnt, onehot);
      end
      cyc(4'b0000, 1'b0);
      check($sformatf("single%0d_last", a), gnt, onehot);
      cyc(4'b0000, 1'b0);
      check($sformatf("single%0d_released", a), gnt, 4'b0000);
      cyc(4'b0000, 1'b0);
    end

    // Priority: req_1 beats req_3; req_3 served after one IDLE cycle.
    cyc(4'b1010, 1'b0);
    check("prio_latency", gnt, 4'b0000);
    cyc(4'b1010, 1'b0);
    check("prio_gnt1", gnt, 4'b0010);
    cyc(4'b1000, 1'b0);
    check("prio_gnt1_tail", gnt, 4'b0010);
    cyc(4'b1000, 1'b0);
    check("prio_idle_gap", gnt, 4'b0000);
    cyc(4'b1000, 1'b0);
    check("prio_gnt3", gnt, 4'b1000);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    check("prio_done", gnt, 4'b0000);

    // No preemption: req_0 waits while agent 2 holds the resource.
    cyc(4'b0100, 1'b0);
    cyc(4'b0100, 1'b0);
    check("nopre_gnt2", gnt, 4'b0100);
    cyc(4'b0101, 1'b0);
    check("nopre_hold_a", gnt, 4'b0100);
    cyc(4'b0101, 1'b0);
    check("nopre_hold_b", gnt, 4'b0100);
    cyc(4'b0001, 1'b0);
    check("nopre_gnt2_tail", gnt, 4'b0100);
    cyc(4'b0001, 1'b0);
    check("nopre_idle_gap", gnt, 4'b0000);
    cyc(4'b0001, 1'b0);
    check("nopre_gnt0", gnt, 4'b0001);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);

    // Reset pulse in the middle of a grant.
    cyc(4'b0010, 1'b0);
    cyc(4'b0010, 1'b0);
    check("midrst_gnt1", gnt, 4'b0010);
    cyc(4'b0010, 1'b1);
    check("midrst_reset_edge", gnt, 4'b0000);
    cyc(4'b0010, 1'b0);
    check("midrst_rearbitrate", gnt, 4'b0000);
    cyc(4'b0010, 1'b0);
    check("midrst_regrant", gnt, 4'b0010);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);

    // Randomized traffic: requests tend to persist, occasional resets.
    rnd_req = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(3, 0) == 0) rnd_req[i] = ~rnd_req[i];
      end
      cyc(rnd_req, ($urandom_range(63, 0) == 0) ? 1'b1 : 1'b0);
    end
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    cyc(4'b0000, 1'b0);
    check("final_idle", gnt, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
